// File: rtl/cordic_pkg.sv
// Shared fixed-point constants, state encoding and table rescaling for the CORDIC ln unit.
package cordic_pkg;

  localparam int unsigned FRAC      = 16;
  localparam int unsigned ONE       = 65536;
  localparam int unsigned LN2_Q16   = 45426;
  localparam int unsigned GUARD_DEF = 8;
  localparam int unsigned REP_A     = 4;
  localparam int unsigned REP_B     = 13;

  // Master constants are held with 24 fractional bits and rescaled to the working precision.
  localparam int unsigned TAB_FRAC  = 24;
  localparam int unsigned LN2_Q24   = 11629080;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ITER,
    S_POST,
    S_DONE
  } state_t;

  // Round-to-nearest conversion of a Q.24 constant to 'frac' fractional bits.
  function automatic logic [63:0] q24_rescale(input logic [31:0] v, input int unsigned frac);
    if (frac >= TAB_FRAC) return 64'(v) << (frac - TAB_FRAC);
    return (64'(v) + (64'(1) << (TAB_FRAC - 1 - frac))) >> (TAB_FRAC - frac);
  endfunction

endpackage

// File: rtl/cordic_atanh_rom.sv
// Combinational table of atanh(2^-i) for i=1..16 in Q16.(16+GUARD).
module cordic_atanh_rom
  import cordic_pkg::*;
#(
  parameter int unsigned GUARD = GUARD_DEF
) (
  input  logic [4:0]            idx,
  output logic signed [31+GUARD:0] atanh_val
);

  localparam int unsigned W = 32 + GUARD;

  logic [31:0] raw;

  // round(atanh(2^-i) * 2^24)
  always_comb begin
    raw = '0;
    case (idx)
      5'd1:    raw = 32'd9215828;
      5'd2:    raw = 32'd4285116;
      5'd3:    raw = 32'd2108178;
      5'd4:    raw = 32'd1049945;
      5'd5:    raw = 32'd524459;
      5'd6:    raw = 32'd262165;
      5'd7:    raw = 32'd131075;
      5'd8:    raw = 32'd65536;
      5'd9:    raw = 32'd32768;
      5'd10:   raw = 32'd16384;
      5'd11:   raw = 32'd8192;
      5'd12:   raw = 32'd4096;
      5'd13:   raw = 32'd2048;
      5'd14:   raw = 32'd1024;
      5'd15:   raw = 32'd512;
      5'd16:   raw = 32'd256;
      default: raw = '0;
    endcase
  end

  always_comb atanh_val = W'(q24_rescale(raw, FRAC + GUARD));

endmodule

// File: rtl/cordic_ln.sv
// Iterative hyperbolic-vectoring CORDIC computing ln(a) for a Q16.16 operand.
module cordic_ln
  import cordic_pkg::*;
#(
  parameter int unsigned GUARD  = GUARD_DEF,
  parameter int unsigned N_ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ln_out,
  output logic        err
);

  localparam int unsigned W  = 32 + GUARD;
  localparam int unsigned IW = 5;

  localparam logic signed [W-1:0] ONE_I = W'(64'(ONE) << GUARD);
  localparam logic signed [W-1:0] LN2_I = W'(q24_rescale(32'(LN2_Q24), FRAC + GUARD));
  localparam logic signed [W-1:0] RND   = W'((64'(1) << GUARD) >> 1);

  state_t                state, state_n;
  logic [30:0]           a_q, a_n;
  logic signed [W-1:0]   x, y, z, x_n, y_n, z_n;
  logic [IW-1:0]         iter, iter_n;
  logic                  rep, rep_n;
  logic signed [5:0]     k, k_n;
  logic                  bad, bad_n;
  logic                  in_ready_n, out_valid_n, err_n;
  logic [31:0]           ln_n;

  logic signed [W-1:0]   atanh_val;
  logic signed [W-1:0]   xs, ys, m, k_w, ln_w, rnd_w;
  logic [W-1:0]          a_ext;
  logic [4:0]            p;
  logic                  hold;

  cordic_atanh_rom #(.GUARD(GUARD)) u_rom (
    .idx       (iter),
    .atanh_val (atanh_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      a_q       <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      iter      <= '0;
      rep       <= 1'b0;
      k         <= '0;
      bad       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ln_out    <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      a_q       <= a_n;
      x         <= x_n;
      y         <= y_n;
      z         <= z_n;
      iter      <= iter_n;
      rep       <= rep_n;
      k         <= k_n;
      bad       <= bad_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      ln_out    <= ln_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    a_n         = a_q;
    x_n         = x;
    y_n         = y;
    z_n         = z;
    iter_n      = iter;
    rep_n       = rep;
    k_n         = k;
    bad_n       = bad;
    out_valid_n = out_valid;
    ln_n        = ln_out;
    err_n       = err;
    p           = '0;
    m           = '0;
    a_ext       = W'(a_q) << GUARD;
    k_w         = W'(k);
    ln_w        = '0;
    rnd_w       = '0;
    xs          = x >>> iter;
    ys          = y >>> iter;
    hold        = ((iter == IW'(REP_A)) || (iter == IW'(REP_B))) && !rep;

    unique case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_n = a[30:0];
          // Non-positive operands skip the datapath and report through POST.
          if (a[31] || (a == '0)) begin
            bad_n   = 1'b1;
            state_n = S_POST;
          end else begin
            bad_n   = 1'b0;
            state_n = S_NORM;
          end
        end
      end

      S_NORM: begin
        for (int b = 0; b < 31; b++) begin
          if (a_q[b]) p = 5'(b);
        end
        k_n = $signed({1'b0, p}) - 6'sd15;
        if (p >= 5'd15) m = a_ext >> (p - 5'd15);
        else            m = a_ext << (5'd15 - p);
        x_n     = m + ONE_I;
        y_n     = m - ONE_I;
        z_n     = '0;
        iter_n  = IW'(1);
        rep_n   = 1'b0;
        state_n = S_ITER;
      end

      S_ITER: begin
        // Drive y toward zero; z accumulates atanh(y0/x0) = ln(m)/2.
        if (y[W-1]) begin
          x_n = x + ys;
          y_n = y + xs;
          z_n = z - atanh_val;
        end else begin
          x_n = x - ys;
          y_n = y - xs;
          z_n = z + atanh_val;
        end
        if (hold) begin
          rep_n = 1'b1;
        end else begin
          rep_n  = 1'b0;
          iter_n = iter + IW'(1);
          if (iter == IW'(N_ITER)) state_n = S_POST;
        end
      end

      S_POST: begin
        ln_w  = (z <<< 1) + k_w * LN2_I;
        rnd_w = ln_w + RND;
        if (bad) begin
          ln_n  = 32'h8000_0000;
          err_n = 1'b1;
        end else begin
          ln_n  = 32'(rnd_w >>> GUARD);
          err_n = 1'b0;
        end
        out_valid_n = 1'b1;
        state_n     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase

    in_ready_n = (state_n == S_IDLE);
  end

endmodule

// File: tb/tb_cordic_ln.sv
// Self-checking bench for cordic_ln: directed vectors, corner sequences and random operands vs. a real-valued ln model.
module tb_cordic_ln;
  import cordic_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ln_out;
  logic        err;

  int total = 0;
  int bad   = 0;

  cordic_ln dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ln_out    (ln_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    int          exp_ln;
    int          tol;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  function automatic int ref_ln(input logic [31:0] v);
    real r;
    r = $ln(real'(v) / 65536.0) * 65536.0;
    return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic chk_tol(input string name, input longint got, input longint want, input longint tol);
    total++;
    if (got > want + tol || got < want - tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d +/- %0d", name, got, want, tol);
    end
  endtask

  // Counts edges (sampled 1 time unit after each) until out_valid, bounded.
  task automatic wait_valid(output int lat, output int busy_rdy);
    lat = 0;
    busy_rdy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_rdy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] val, output logic [31:0] r, output logic e, output int lat);
    int waitc;
    int busy_rdy;
    waitc = 0;
    @(negedge clk);
    a = val;
    in_valid = 1'b1;
    out_ready = 1'b0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept_wait", longint'(waitc < 100), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat, busy_rdy);
    chk("busy_in_ready", busy_rdy, 0);
    r = ln_out;
    e = err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("take_ov_ir", {out_valid, in_ready}, 2'b01);
  endtask

  logic [31:0] r;
  logic        e;
  int          lat;
  int          busy;
  logic [31:0] v;
  int          sh;
  int          seen;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;

    vecs[0] = '{32'h0001_0000, 0,       4, 1'b0};
    vecs[1] = '{32'd131072,    int'(LN2_Q16), 4, 1'b0};
    vecs[2] = '{32'd178145,    65536,   4, 1'b0};
    vecs[3] = '{32'h0000_0001, -726817, 8, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 681391,  8, 1'b0};
    vecs[5] = '{32'h0000_0000, 0,       0, 1'b1};
    vecs[6] = '{32'hFFFF_0000, 0,       0, 1'b1};
    vecs[7] = '{32'd32768,     -45426,  4, 1'b0};
    vecs[8] = '{32'd262144,    90852,   4, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ln_out", ln_out, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 9; n++) begin
      run_op(vecs[n].a, r, e, lat);
      chk($sformatf("vec%0d_err", n), e, vecs[n].exp_err);
      if (vecs[n].exp_err) chk($sformatf("vec%0d_ln", n), r, 32'h8000_0000);
      else chk_tol($sformatf("vec%0d_ln", n), longint'($signed(r)), vecs[n].exp_ln, vecs[n].tol);
      chk($sformatf("vec%0d_lat", n), lat, vecs[n].exp_err ? 1 : 20);
    end

    // Backpressure: result held while a second operand waits on in_valid.
    @(negedge clk);
    a = 32'd196608;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    a = 32'd32768;
    wait_valid(lat, busy);
    chk("bp_lat", lat, 20);
    chk("bp_busy_ready", busy, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_flags", {out_valid, in_ready, err}, 3'b100);
      chk_tol("bp_hold_ln", longint'($signed(ln_out)), ref_ln(32'd196608), 4);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_accepted", in_ready, 0);
    wait_valid(lat, busy);
    chk("b2b_lat", lat, 20);
    chk_tol("b2b_ln", longint'($signed(ln_out)), -45426, 4);
    chk("b2b_err", err, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_take", {out_valid, in_ready}, 2'b01);

    // Asynchronous reset in the middle of the iterations.
    @(negedge clk);
    a = 32'd262144;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_flags", {in_ready, out_valid, err}, 3'b100);
    chk("arst_ln_out", ln_out, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("arst_no_output", seen, 0);
    run_op(32'd262144, r, e, lat);
    chk_tol("arst_fresh_ln", longint'($signed(r)), 90852, 4);
    chk("arst_fresh_lat", lat, 20);
    chk("arst_fresh_err", e, 0);

    // Random operands spread across the whole exponent range, some negative.
    for (int n = 0; n < 30; n++) begin
      sh = $urandom_range(0, 30);
      v = ($urandom() >> 1) >> sh;
      if (v == '0) v = 32'd1;
      if ($urandom_range(0, 9) == 0) v = $urandom() | 32'h8000_0000;
      run_op(v, r, e, lat);
      if (v[31]) begin
        chk($sformatf("rnd%0d_err", n), e, 1);
        chk($sformatf("rnd%0d_ln", n), r, 32'h8000_0000);
      end else begin
        chk($sformatf("rnd%0d_err", n), e, 0);
        chk_tol($sformatf("rnd%0d_ln a=%0d", n, v), longint'($signed(r)), ref_ln(v), 4);
        chk($sformatf("rnd%0d_lat", n), lat, 20);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
